audio_tone_gen: RTL

- Downstream consumer of the clock block's 48 kHz audio clock and pixel clock.
- On every rising edge of the audio clock, produces one stereo 16-bit signed PCM sample: square or triangle tone from a phase accumulator, with attenuation and mute.
- Samples are buffered in a small FIFO and handed to the HDMI audio packetizer over a valid/ready handshake.
- Runs entirely in the pixel clock domain.

---
 rtl/audio_tone_gen_pkg.sv | 38 +++
 rtl/audio_tone_gen_sample_fifo.sv | 70 +++++++
 rtl/audio_tone_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/audio_tone_gen_pkg.sv
// Shared constants, waveform selector type and sample-shaping helpers for the audio tone path.
// Latency: combinational helpers only.
// Backpressure: n/a.
package audio_tone_gen_pkg;

    // Pixel clock in kHz and audio sample rate in Hz, shared with the clock block.
    localparam int CLKFRQ         = 74250;
    localparam int AUDIO_RATE     = 48000;
    localparam int AUDIO_SAMPLE_W = 16;

    typedef enum logic {
        WAVE_SQUARE   = 1'b0,
        WAVE_TRIANGLE = 1'b1
    } wave_t;

    // Raw full-scale tone from the top 16 phase bits.
    // The square wave stays symmetric (+/-32767). The triangle folds the upper half
    // of the phase back down, then recentres it around zero by flipping the MSB.
    function automatic logic [AUDIO_SAMPLE_W-1:0] tone_shape(input logic [15:0] u,
                                                             input wave_t       wave);
        logic [14:0] t;
        t = u[15] ? ~u[14:0] : u[14:0];
        if (wave == WAVE_TRIANGLE) begin
            return {t, 1'b0} ^ 16'h8000;
        end
        return u[15] ? 16'h8001 : 16'h7FFF;
    endfunction

    // Two's-complement negation that clamps -32768 to +32767 instead of wrapping.
    function automatic logic signed [AUDIO_SAMPLE_W-1:0] sat_neg(
        input logic signed [AUDIO_SAMPLE_W-1:0] x);
        if (x == 16'sh8000) begin
            return 16'sh7FFF;
        end
        return -x;
    endfunction

endpackage

// File: rtl/audio_tone_gen_sample_fifo.sv
// Show-ahead sample buffer between the tone datapath and the audio packetizer.
// Latency: a pushed entry is visible at the head one edge after the push; no empty-bypass.
// Backpressure: holds the head while pop_rdy is low; a push into a full FIFO with no pop is dropped and flagged.
// Ports: clk/rst (async active-high); push_vld/push_dat write side; pop_rdy read strobe;
//        head_vld/head_dat show-ahead head; level occupancy; overflow sticky drop flag.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_pop  = pop_rdy & ~empty;
    assign do_push = push_vld & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_vld & ~do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head_vld = ~empty;
    assign head_dat = mem[rd_ptr];
    assign level    = count;

endmodule

// File: rtl/audio_tone_gen.sv
// Stereo square/triangle tone source, one sample per audio-clock rising edge, buffered for the HDMI packetizer.
// Latency: sample reaches the FIFO head two pixel-clock edges after the edge that sees the audio tick.
// Backpressure: valid/ready at the FIFO head; samples arriving into a full FIFO are dropped and O_overflow sticks.
// Ports: I_clk_pixel/I_reset clock and async reset; I_clk_audio 48 kHz tick source; I_tone_step,
//        I_wave_sel, I_atten, I_mute tone controls; O_sample_l/r, O_valid, I_ready sample stream;
//        O_overflow sticky drop flag; O_level FIFO occupancy.
module audio_tone_gen
    import audio_tone_gen_pkg::*;
#(
    parameter int PHASE_W    = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int RIGHT_INV  = 0
) (
    input  logic                          I_clk_pixel,
    input  logic                          I_reset,
    input  logic                          I_clk_audio,
    input  logic [PHASE_W-1:0]            I_tone_step,
    input  logic                          I_wave_sel,
    input  logic [3:0]                    I_atten,
    input  logic                          I_mute,
    output logic [AUDIO_SAMPLE_W-1:0]     O_sample_l,
    output logic [AUDIO_SAMPLE_W-1:0]     O_sample_r,
    output logic                          O_valid,
    input  logic                          I_ready,
    output logic                          O_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   O_level
);

    logic                              prev_audio;
    logic                              tick;
    logic [PHASE_W-1:0]                phase;
    logic                              calc_vld;
    logic                              push_vld;
    logic [AUDIO_SAMPLE_W-1:0]         samp_l;
    logic [AUDIO_SAMPLE_W-1:0]         samp_r;
    logic [15:0]                       u;
    logic signed [AUDIO_SAMPLE_W-1:0]  shaped;
    logic signed [AUDIO_SAMPLE_W-1:0]  atten_s;
    logic signed [AUDIO_SAMPLE_W-1:0]  left_s;
    logic signed [AUDIO_SAMPLE_W-1:0]  right_s;
    logic [2*AUDIO_SAMPLE_W-1:0]       head_dat;

    // I_clk_audio is already registered in this domain; prev_audio resets high so a
    // level that is high at reset release is not mistaken for a rising edge.
    assign tick = I_clk_audio & ~prev_audio;
    assign u    = phase[PHASE_W-1 -: 16];

    // Tone controls are taken live at the compute edge, one edge after the phase step.
    always_comb begin
        shaped  = $signed(tone_shape(u, wave_t'(I_wave_sel)));
        atten_s = shaped >>> I_atten;
        left_s  = I_mute ? '0 : atten_s;
        right_s = (RIGHT_INV != 0) ? sat_neg(left_s) : left_s;
    end

    always_ff @(posedge I_clk_pixel or posedge I_reset) begin
        if (I_reset) begin
            prev_audio <= 1'b1;
            phase      <= '0;
            calc_vld   <= 1'b0;
            push_vld   <= 1'b0;
            samp_l     <= '0;
            samp_r     <= '0;
        end else begin
            prev_audio <= I_clk_audio;
            if (tick) begin
                phase <= phase + I_tone_step;
            end
            calc_vld <= tick;
            push_vld <= calc_vld;
            if (calc_vld) begin
                samp_l <= left_s;
                samp_r <= right_s;
            end
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*AUDIO_SAMPLE_W)
    ) u_fifo (
        .clk      (I_clk_pixel),
        .rst      (I_reset),
        .push_vld (push_vld),
        .push_dat ({samp_l, samp_r}),
        .pop_rdy  (I_ready),
        .head_vld (O_valid),
        .head_dat (head_dat),
        .level    (O_level),
        .overflow (O_overflow)
    );

    assign O_sample_l = head_dat[2*AUDIO_SAMPLE_W-1:AUDIO_SAMPLE_W];
    assign O_sample_r = head_dat[AUDIO_SAMPLE_W-1:0];

endmodule
